// File: rtl/nand_gate.sv
// Bitwise NAND of two WIDTH-bit operands with a combinational result and a
// one-cycle registered, valid-qualified result carrying all-ones and popcount status.
module nand_gate #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           Y_comb,
    output logic [WIDTH-1:0]           Y,
    output logic                       out_valid,
    output logic                       all_ones,
    output logic [$clog2(WIDTH+1)-1:0] ones_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] y_d, y_q;
    logic             valid_d, valid_q;
    logic             all_ones_d, all_ones_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        logic [WIDTH-1:0] t;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t = v >> i;
            c = c + CNT_W'(t[0]);
        end
        return c;
    endfunction

    assign Y_comb = ~(A & B);

    // Status is derived from the same value that lands in Y, so the flags can never disagree with it.
    always_comb begin
        valid_d    = in_valid;
        y_d        = y_q;
        all_ones_d = all_ones_q;
        cnt_d      = cnt_q;
        if (in_valid) begin
            y_d        = Y_comb;
            all_ones_d = &Y_comb;
            cnt_d      = popcount(Y_comb);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q        <= '1;
            valid_q    <= 1'b0;
            all_ones_q <= 1'b1;
            cnt_q      <= CNT_W'(WIDTH);
        end else begin
            y_q        <= y_d;
            valid_q    <= valid_d;
            all_ones_q <= all_ones_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = valid_q;
    assign all_ones  = all_ones_q;
    assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_nand_gate.sv
// Directed self-checking bench for nand_gate at WIDTH=4.
module tb_nand_gate;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] A, B;
    logic         in_valid;
    logic [W-1:0] Y_comb, Y;
    logic         out_valid, all_ones;
    logic [2:0]   ones_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    nand_gate #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .in_valid (in_valid),
        .Y_comb   (Y_comb),
        .Y        (Y),
        .out_valid(out_valid),
        .all_ones (all_ones),
        .ones_cnt (ones_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; A = 4'b1100; B = 4'b1010;
        #1;
        n_checks++;
        if (Y_comb !== 4'b0111) begin n_fail++; $display("FAIL reset_ycomb got=%b exp=0111", Y_comb); end
        @(posedge clk); #1;
        n_checks++;
        if (Y !== 4'b1111) begin n_fail++; $display("FAIL reset_y got=%b exp=1111", Y); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (all_ones !== 1'b1) begin n_fail++; $display("FAIL reset_all_ones got=%b exp=1", all_ones); end
        n_checks++;
        if (ones_cnt !== 3'd4) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=4", ones_cnt); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (Y !== 4'b1111 || out_valid !== 1'b0 || ones_cnt !== 3'd4)
            begin n_fail++; $display("FAIL post_reset_idle got Y=%b v=%b cnt=%0d exp Y=1111 v=0 cnt=4", Y, out_valid, ones_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av [4] = '{4'b0000, 4'b0010, 4'b0011, 4'b0100};
        logic [W-1:0] bv [4] = '{4'b0000, 4'b1000, 4'b0100, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A = av[i]; B = bv[i]; in_valid = 1'b1;
            #1;
            n_checks++;
            if (Y_comb !== 4'b1111) begin n_fail++; $display("FAIL b2b_ycomb[%0d] got=%b exp=1111", i, Y_comb); end
            @(posedge clk); #1;
            n_checks++;
            if (Y !== 4'b1111 || out_valid !== 1'b1 || all_ones !== 1'b1 || ones_cnt !== 3'd4)
                begin n_fail++; $display("FAIL b2b_reg[%0d] got Y=%b v=%b all=%b cnt=%0d exp Y=1111 v=1 all=1 cnt=4", i, Y, out_valid, all_ones, ones_cnt); end
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic test_all_clear();
        @(negedge clk); A = 4'b1111; B = 4'b1111; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (Y !== 4'b0000 || all_ones !== 1'b0 || ones_cnt !== 3'd0 || out_valid !== 1'b1)
            begin n_fail++; $display("FAIL all_clear got Y=%b all=%b cnt=%0d v=%b exp Y=0000 all=0 cnt=0 v=1", Y, all_ones, ones_cnt, out_valid); end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || Y !== 4'b0000)
            begin n_fail++; $display("FAIL all_clear_idle got Y=%b v=%b exp Y=0000 v=0", Y, out_valid); end
    endtask

    task automatic test_mixed();
        logic [W-1:0] av [3] = '{4'b1010, 4'b1000, 4'b0001};
        logic [W-1:0] bv [3] = '{4'b1110, 4'b1001, 4'b0001};
        logic [W-1:0] ye [3] = '{4'b0101, 4'b0111, 4'b1110};
        logic [2:0]   ce [3] = '{3'd2, 3'd3, 3'd3};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = av[i]; B = bv[i]; in_valid = 1'b1;
            #1;
            n_checks++;
            if (Y_comb !== ye[i]) begin n_fail++; $display("FAIL mixed_ycomb[%0d] got=%b exp=%b", i, Y_comb, ye[i]); end
            @(posedge clk); #1;
            n_checks++;
            if (Y !== ye[i] || ones_cnt !== ce[i] || all_ones !== 1'b0 || out_valid !== 1'b1)
                begin n_fail++; $display("FAIL mixed_reg[%0d] got Y=%b cnt=%0d all=%b v=%b exp Y=%b cnt=%0d all=0 v=1", i, Y, ones_cnt, all_ones, out_valid, ye[i], ce[i]); end
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic test_hold();
        logic [W-1:0] av [3] = '{4'b1111, 4'b1100, 4'bxxxx};
        logic [W-1:0] bv [3] = '{4'b1111, 4'b0100, 4'bxxxx};
        logic [W-1:0] ye [2] = '{4'b0000, 4'b1011};
        @(negedge clk); A = 4'b0110; B = 4'b0111; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (Y !== 4'b1001 || ones_cnt !== 3'd2 || out_valid !== 1'b1)
            begin n_fail++; $display("FAIL hold_capture got Y=%b cnt=%0d v=%b exp Y=1001 cnt=2 v=1", Y, ones_cnt, out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0; A = av[i]; B = bv[i];
            #1;
            if (i < 2) begin
                n_checks++;
                if (Y_comb !== ye[i]) begin n_fail++; $display("FAIL hold_ycomb[%0d] got=%b exp=%b", i, Y_comb, ye[i]); end
            end
            @(posedge clk); #1;
            n_checks++;
            if (Y !== 4'b1001 || out_valid !== 1'b0 || ones_cnt !== 3'd2 || all_ones !== 1'b0)
                begin n_fail++; $display("FAIL hold_reg[%0d] got Y=%b v=%b cnt=%0d all=%b exp Y=1001 v=0 cnt=2 all=0", i, Y, out_valid, ones_cnt, all_ones); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); A = 4'b0011; B = 4'b1111; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (Y !== 4'b1100 || out_valid !== 1'b1 || ones_cnt !== 3'd2)
            begin n_fail++; $display("FAIL async_pre got Y=%b v=%b cnt=%0d exp Y=1100 v=1 cnt=2", Y, out_valid, ones_cnt); end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || Y !== 4'b1111 || all_ones !== 1'b1 || ones_cnt !== 3'd4)
            begin n_fail++; $display("FAIL async_reset got Y=%b v=%b all=%b cnt=%0d exp Y=1111 v=0 all=1 cnt=4", Y, out_valid, all_ones, ones_cnt); end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || Y !== 4'b1111)
            begin n_fail++; $display("FAIL reset_held got Y=%b v=%b exp Y=1111 v=0", Y, out_valid); end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_all_clear();
        test_mixed();
        test_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
